// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned HALF_WIDTH  = 16;
  localparam logic [1:0]  RVC_OPC_MASK = 2'b11;

  typedef struct packed {
    logic                   err;
    logic [INSTR_WIDTH-1:0] data;
  } fifo_entry_t;

  function automatic logic is_rvc(input logic [HALF_WIDTH-1:0] half);
    return (half[1:0] & RVC_OPC_MASK) != RVC_OPC_MASK;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Shift-register word FIFO: head is always entry 0, so head and head+1 are fixed taps.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       push,
  input  fifo_entry_t                push_entry,
  input  logic                       pop,
  output fifo_entry_t                head,
  output fifo_entry_t                next,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fifo_entry_t       mem [DEPTH];
  logic [CW-1:0]     occ;
  logic [CW-1:0]     wr_idx;

  // A pop shifts everything down first, so the tail slot moves by one too.
  assign wr_idx    = occ - CW'(pop);
  assign head      = mem[0];
  assign next      = mem[1];
  assign occupancy = occ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      occ <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) mem[i] <= push_entry;
        end
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: bus request control, stale-response discard,
// word FIFO and RVC aligner presenting one 16/32-bit instruction per cycle.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          run, stop, req_hold, redir_pend;
  logic [31:0]   pc_q, addr_q, redir_addr, br_pc, br_word;
  logic [OW-1:0] outstanding, discard, out_next;
  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  fifo_entry_t   w0, w1;
  logic          issue_ok, grant, push, pop, consume;
  logic [31:0]   window;
  logic [HALF_WIDTH-1:0] lo_half;
  logic          compressed, need_two, pop_needed;

  assign br_pc   = branch_addr_i & 32'hFFFF_FFFE;
  assign br_word = br_pc & 32'hFFFF_FFFC;

  // Issue is decided on registered counts only; run keeps the request low
  // for the first cycle out of reset.
  assign inflight    = {1'b0, occ} + (CW+1)'(outstanding);
  assign issue_ok    = !stop && (outstanding < OW'(MAX_OUTSTANDING)) &&
                       (inflight < (CW+1)'(DEPTH));
  assign instr_req_o = run && (req_hold || issue_ok);
  assign grant       = instr_req_o && instr_gnt_i;
  assign out_next    = outstanding + OW'(grant) - OW'(instr_rvalid_i);
  assign push        = instr_rvalid_i && (discard == '0);

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (branch_i),
    .push       (push),
    .push_entry ('{err: instr_err_i, data: instr_rdata_i}),
    .pop        (pop),
    .head       (w0),
    .next       (w1),
    .occupancy  (occ)
  );

  // Odd-halfword PC selects {w1[15:0], w0[31:16]} from the two-word window.
  always_comb begin
    window     = 32'({w1.data, w0.data} >> {pc_q[1], 4'b0000});
    lo_half    = window[HALF_WIDTH-1:0];
    compressed = is_rvc(lo_half);
    need_two   = pc_q[1] && !compressed;
    valid_o    = need_two ? (occ >= CW'(2)) : (occ != '0);
    instr_o    = compressed ? {{HALF_WIDTH{1'b0}}, lo_half} : window;
    err_o      = valid_o && (w0.err || (need_two && w1.err));
    pop_needed = pc_q[1] || !compressed;
  end

  assign consume         = valid_o && ready_i && !branch_i;
  assign pop             = consume && pop_needed;
  assign is_compressed_o = compressed;
  assign pc_o            = pc_q;
  assign instr_addr_o    = addr_q;
  assign busy_o          = (outstanding != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run         <= 1'b0;
      stop        <= 1'b0;
      req_hold    <= 1'b0;
      redir_pend  <= 1'b0;
      redir_addr  <= '0;
      pc_q        <= PC_RESET;
      addr_q      <= PC_RESET & 32'hFFFF_FFFC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= out_next;
      req_hold    <= instr_req_o && !instr_gnt_i;
      if (branch_i) begin
        pc_q    <= br_pc;
        stop    <= 1'b0;
        discard <= out_next;
        // An ungranted request keeps its old address; the target follows it.
        if (instr_req_o && !instr_gnt_i) begin
          redir_pend <= 1'b1;
          redir_addr <= br_word;
        end else begin
          redir_pend <= 1'b0;
          addr_q     <= br_word;
        end
      end else begin
        if (consume) pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
        if (push && instr_err_i) stop <= 1'b1;
        discard <= discard - OW'(instr_rvalid_i && (discard != '0))
                           + OW'(grant && redir_pend);
        if (grant) begin
          addr_q     <= redir_pend ? redir_addr : addr_q + 32'd4;
          redir_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with an in-order, 1-cycle-latency bus model.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        branch_i = 1'b0, ready_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        valid_o, is_compressed_o, err_o, instr_req_o, busy_o;
  logic [31:0] instr_o, pc_o, instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;

  int vectors = 0, miscompares = 0;
  logic [31:0] mem_over [logic [31:0]];
  bit          err_over [logic [31:0]];
  logic [31:0] pend_q [$];
  bit          rsp_en = 1'b1;

  instr_prefetch_buffer #(.PC_RESET(32'h100), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rstn(rstn), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .is_compressed_o(is_compressed_o), .err_o(err_o), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Default memory image: a 32-bit instruction tagged with its own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return {a[23:0], 8'h13};
  endfunction

  function automatic bit err_at(input logic [31:0] a);
    if (err_over.exists(a)) return err_over[a];
    return 1'b0;
  endfunction

  // Advance to the next falling edge and drive the bus for the coming rising edge.
  task automatic tick();
    logic [31:0] a;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    instr_err_i    = 1'b0;
    instr_rdata_i  = '0;
    if (rsp_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = word_at(a);
      instr_err_i    = err_at(a);
    end
    instr_gnt_i = 1'b1;
    if (rstn && instr_req_o) pend_q.push_back(instr_addr_o);
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rstn = 1'b0; branch_i = 1'b0; ready_i = rdy; rsp_en = 1'b1;
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    pend_q.delete();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    mem_over.delete(); err_over.delete();
    @(negedge clk);
    rstn = 1'b0; pend_q.delete();
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_o); end
    vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", instr_req_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
    vectors++; if (pc_o !== 32'h100) begin miscompares++; $display("FAIL reset_pc got %h want 00000100", pc_o); end
    vectors++; if (instr_addr_o !== 32'h100) begin miscompares++; $display("FAIL reset_addr got %h want 00000100", instr_addr_o); end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    mem_over.delete(); err_over.delete();
    do_reset(1'b1);
    tick();
    vectors++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin miscompares++; $display("FAIL stream_first_req got req=%b addr=%h want 1 00000100", instr_req_o, instr_addr_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_c1_valid got %b want 0", valid_o); end
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_c2_valid got %b want 0", valid_o); end
    vectors++; if (instr_addr_o !== 32'h104) begin miscompares++; $display("FAIL stream_c2_addr got %h want 00000104", instr_addr_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      epc = 32'h100 + 32'(4 * k);
      vectors++; if (valid_o !== 1'b1 || pc_o !== epc || instr_o !== {epc[23:0], 8'h13} || is_compressed_o !== 1'b0) begin
        miscompares++; $display("FAIL stream_instr%0d got v=%b pc=%h instr=%h c=%b want 1 %h %h 0", k, valid_o, pc_o, instr_o, is_compressed_o, epc, {epc[23:0], 8'h13});
      end
    end
  endtask

  task automatic test_compressed();
    logic [31:0] epc [4];
    logic [31:0] ein [4];
    logic        ec  [4];
    mem_over.delete(); err_over.delete();
    mem_over[32'h100] = 32'h0001_4505;
    mem_over[32'h104] = 32'h0000_0513;
    epc = '{32'h100, 32'h102, 32'h104, 32'h108};
    ein = '{32'h0000_4505, 32'h0000_0001, 32'h0000_0513, 32'h0001_0813};
    ec  = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(1'b1);
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (valid_o !== 1'b1 || pc_o !== epc[k] || instr_o !== ein[k] || is_compressed_o !== ec[k]) begin
        miscompares++; $display("FAIL rvc_seq%0d got v=%b pc=%h instr=%h c=%b want 1 %h %h %b", k, valid_o, pc_o, instr_o, is_compressed_o, epc[k], ein[k], ec[k]);
      end
    end
  endtask

  task automatic test_unaligned();
    mem_over.delete(); err_over.delete();
    mem_over[32'h100] = 32'h0513_4505;
    mem_over[32'h104] = 32'hABCD_0041;
    do_reset(1'b1);
    tick(); tick();
    rsp_en = 1'b0;
    tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h0000_4505) begin miscompares++; $display("FAIL unal_first got v=%b pc=%h instr=%h want 1 00000100 00004505", valid_o, pc_o, instr_o); end
    tick();
    vectors++; if (valid_o !== 1'b0 || pc_o !== 32'h102) begin miscompares++; $display("FAIL unal_wait1 got v=%b pc=%h want 0 00000102", valid_o, pc_o); end
    tick();
    vectors++; if (valid_o !== 1'b0 || instr_req_o !== 1'b0 || busy_o !== 1'b1) begin miscompares++; $display("FAIL unal_wait2 got v=%b req=%b busy=%b want 0 0 1", valid_o, instr_req_o, busy_o); end
    rsp_en = 1'b1;
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL unal_wait3 got v=%b want 0", valid_o); end
    tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h102 || instr_o !== 32'h0041_0513 || is_compressed_o !== 1'b0) begin
      miscompares++; $display("FAIL unal_span got v=%b pc=%h instr=%h c=%b want 1 00000102 00410513 0", valid_o, pc_o, instr_o, is_compressed_o);
    end
    tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h106 || instr_o !== 32'h0000_ABCD || is_compressed_o !== 1'b1) begin
      miscompares++; $display("FAIL unal_tail got v=%b pc=%h instr=%h c=%b want 1 00000106 0000abcd 1", valid_o, pc_o, instr_o, is_compressed_o);
    end
  endtask

  task automatic test_branch_outstanding();
    int  waited;
    bit  seen;
    mem_over.delete(); err_over.delete();
    do_reset(1'b1);
    tick();
    rsp_en = 1'b0;
    tick(); tick();
    vectors++; if (busy_o !== 1'b1 || instr_req_o !== 1'b0 || valid_o !== 1'b0) begin miscompares++; $display("FAIL br_two_out got busy=%b req=%b v=%b want 1 0 0", busy_o, instr_req_o, valid_o); end
    branch_i = 1'b1; branch_addr_i = 32'h201;
    tick();
    branch_i = 1'b0;
    vectors++; if (valid_o !== 1'b0 || instr_addr_o !== 32'h200 || busy_o !== 1'b1) begin miscompares++; $display("FAIL br_after got v=%b addr=%h busy=%b want 0 00000200 1", valid_o, instr_addr_o, busy_o); end
    rsp_en = 1'b1;
    seen = 1'b0; waited = 0;
    while (!seen && waited < 20) begin
      tick();
      waited++;
      if (valid_o === 1'b1) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL br_valid_timeout got none within %0d cycles want valid", waited); end
    vectors++; if (seen && (pc_o !== 32'h200 || instr_o !== 32'h0002_0013)) begin miscompares++; $display("FAIL br_first got pc=%h instr=%h want 00000200 00020013", pc_o, instr_o); end
  endtask

  task automatic test_branch_latency();
    mem_over.delete(); err_over.delete();
    do_reset(1'b1);
    repeat (5) tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h108) begin miscompares++; $display("FAIL lat_pre got v=%b pc=%h want 1 00000108", valid_o, pc_o); end
    branch_i = 1'b1; branch_addr_i = 32'h300;
    tick();
    branch_i = 1'b0;
    vectors++; if (valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin miscompares++; $display("FAIL lat_n1 got v=%b req=%b addr=%h want 0 1 00000300", valid_o, instr_req_o, instr_addr_o); end
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL lat_n2 got v=%b want 0", valid_o); end
    tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h300 || instr_o !== 32'h0003_0013) begin miscompares++; $display("FAIL lat_n3 got v=%b pc=%h instr=%h want 1 00000300 00030013", valid_o, pc_o, instr_o); end
  endtask

  task automatic test_stall();
    logic [31:0] epc;
    mem_over.delete(); err_over.delete();
    do_reset(1'b0);
    repeat (10) tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h0001_0013) begin miscompares++; $display("FAIL stall_hold got v=%b pc=%h instr=%h want 1 00000100 00010013", valid_o, pc_o, instr_o); end
    vectors++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL stall_full got req=%b busy=%b want 0 0", instr_req_o, busy_o); end
    ready_i = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      epc = 32'h100 + 32'(4 * k);
      vectors++; if (valid_o !== 1'b1 || pc_o !== epc || instr_o !== {epc[23:0], 8'h13}) begin
        miscompares++; $display("FAIL stall_resume%0d got v=%b pc=%h instr=%h want 1 %h %h", k, valid_o, pc_o, instr_o, epc, {epc[23:0], 8'h13});
      end
    end
  endtask

  task automatic test_error();
    int reqs;
    mem_over.delete(); err_over.delete();
    err_over[32'h104] = 1'b1;
    do_reset(1'b1);
    repeat (3) tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || err_o !== 1'b0) begin miscompares++; $display("FAIL err_clean got v=%b pc=%h err=%b want 1 00000100 0", valid_o, pc_o, err_o); end
    tick();
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h104 || err_o !== 1'b1) begin miscompares++; $display("FAIL err_flag got v=%b pc=%h err=%b want 1 00000104 1", valid_o, pc_o, err_o); end
    ready_i = 1'b0;
    reqs = (instr_req_o === 1'b1) ? 1 : 0;
    repeat (5) begin
      tick();
      if (instr_req_o === 1'b1) reqs++;
    end
    vectors++; if (reqs != 0) begin miscompares++; $display("FAIL err_stop got %0d request cycles want 0", reqs); end
    vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h104 || err_o !== 1'b1) begin miscompares++; $display("FAIL err_hold got v=%b pc=%h err=%b want 1 00000104 1", valid_o, pc_o, err_o); end
    branch_i = 1'b1; branch_addr_i = 32'h200;
    tick();
    branch_i = 1'b0;
    vectors++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200 || valid_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++; $display("FAIL err_branch got req=%b addr=%h v=%b err=%b want 1 00000200 0 0", instr_req_o, instr_addr_o, valid_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_compressed();
    test_unaligned();
    test_branch_outstanding();
    test_branch_latency();
    test_stall();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
